// File: rtl/mem_port_initiator.sv
// Memory port initiator: drives a registered-output RAM port and returns
// responses in order through a 3-entry response FIFO with registered head.
module mem_port_initiator #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int INDEX_BITS    = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0]    req_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_data,
  output logic                     resp_write,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]    ram_data_in,
  input  logic [DATA_WIDTH-1:0]    ram_data_out
);

  logic                  fire;
  logic                  push;
  logic                  pop;
  logic                  in_flight;
  logic                  fl_write;
  logic [1:0]            count;
  logic [1:0]            n_count;
  logic [1:0]            wr_idx;
  logic [2:0]            credits;
  logic [DATA_WIDTH-1:0] q_data [3];
  logic [DATA_WIDTH-1:0] n_data [3];
  logic [2:0]            q_write;
  logic [2:0]            n_write;

  // Credit check sees only registers; reset gates it so it reads 0 in reset.
  assign credits   = {1'b0, count} + {2'b00, in_flight};
  assign req_ready = ~reset & (credits < 3'd3);
  assign fire      = req_valid & req_ready;

  assign ram_address = {req_address[ADDRESS_WIDTH-1:INDEX_BITS],
                        req_address[INDEX_BITS-1:0]};
  assign ram_data_in = req_data;
  assign ram_we      = fire & req_write;

  assign push       = in_flight;
  assign pop        = resp_valid & resp_ready;
  assign resp_valid = (count != 2'd0);
  assign resp_data  = q_data[0];
  assign resp_write = q_write[0];

  always_comb begin
    n_data  = q_data;
    n_write = q_write;
    n_count = count + {1'b0, push} - {1'b0, pop};
    wr_idx  = pop ? (count - 2'd1) : count;
    if (pop) begin
      n_data[0]  = q_data[1];
      n_data[1]  = q_data[2];
      n_write[0] = q_write[1];
      n_write[1] = q_write[2];
    end
    // Occupancy plus in-flight never exceeds 3, so wr_idx stays in 0..2.
    if (push) begin
      n_data[wr_idx]  = ram_data_out;
      n_write[wr_idx] = fl_write;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_flight <= 1'b0;
      fl_write  <= 1'b0;
      count     <= 2'd0;
      q_write   <= 3'b000;
      for (int i = 0; i < 3; i++) q_data[i] <= '0;
    end else begin
      in_flight <= fire;
      fl_write  <= fire & req_write;
      count     <= n_count;
      q_write   <= n_write;
      q_data    <= n_data;
    end
  end

endmodule

// File: tb/tb_mem_port_initiator.sv
// Scoreboard bench for mem_port_initiator with a write-first
// registered-output RAM model attached to the RAM port.
module tb_mem_port_initiator;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IB = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_address = '0;
  logic [DW-1:0] req_data = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_data;
  logic          resp_write;
  logic          ram_we;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out = '0;

  mem_port_initiator #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .INDEX_BITS(IB)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_address(req_address),
    .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_write(resp_write),
    .ram_we(ram_we), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] ram  [64];
  logic [DW-1:0] refm [64];

  always @(posedge clock) begin
    if (ram_we) begin
      ram[ram_address[IB-1:0]] <= ram_data_in;
      ram_data_out <= ram_data_in;
    end else begin
      ram_data_out <= ram[ram_address[IB-1:0]];
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nfire = 0;
  int n_we = 0;
  int n_rv = 0;
  int fire_cyc[$];
  int resp_cyc[$];
  logic [DW:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Handshakes seen here complete at the following rising edge.
  always @(negedge clock) begin
    logic [DW:0] e;
    if (!reset) begin
      if (ram_we) n_we++;
      if (resp_valid) n_rv++;
      if (resp_valid && resp_ready) begin
        resp_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk("stale_resp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("resp_write", {63'd0, resp_write}, {63'd0, e[DW]});
          chk("resp_data", {32'd0, resp_data}, {32'd0, e[DW-1:0]});
        end
      end
      if (req_valid && req_ready) begin
        nfire++;
        fire_cyc.push_back(cyc);
        if (req_write) begin
          sb.push_back({1'b1, req_data});
          refm[req_address[IB-1:0]] = req_data;
        end else begin
          sb.push_back({1'b0, refm[req_address[IB-1:0]]});
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clock);
    #1;
    req_valid   = v;
    req_write   = w;
    req_address = a;
    req_data    = d;
  endtask

  task automatic drain();
    int k;
    resp_ready = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      step(1);
      k++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int f0;
    int we0;
    int rv0;
    int c0;
    for (int i = 0; i < 64; i++) begin
      ram[i]  = '0;
      refm[i] = '0;
    end
    req_valid = 1'b1;
    req_write = 1'b1;
    #3;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_ram_we", {63'd0, ram_we}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_data", {32'd0, resp_data}, 64'd0);
    chk("rst_resp_write", {63'd0, resp_write}, 64'd0);
    req_valid = 1'b0;
    req_write = 1'b0;
    step(2);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", {63'd0, req_ready}, 64'd1);

    // Idle: no requests means no RAM writes and no responses.
    resp_ready = 1'b1;
    we0 = n_we;
    rv0 = n_rv;
    step(10);
    chk("idle_we", 64'(n_we - we0), 64'd0);
    chk("idle_rv", 64'(n_rv - rv0), 64'd0);

    // Write then immediately read the same address.
    drive(1'b1, 1'b1, 32'd5, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 32'd5, 32'h0);
    drive(1'b0, 1'b0, 32'd0, 32'h0);
    drain();

    // Upper address bits pass through untouched.
    drive(1'b1, 1'b0, 32'hABC0_0005, 32'h0);
    #1;
    chk("addr_pass", {32'd0, ram_address}, 64'hABC0_0005);
    drive(1'b0, 1'b0, 32'd0, 32'h0);
    drain();

    // Preload 8 addresses back to back.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 32'(i), $urandom);
    drive(1'b0, 1'b0, 32'd0, 32'h0);
    drain();

    // Streaming reads with resp_ready held high.
    fire_cyc.delete();
    resp_cyc.delete();
    f0 = nfire;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 32'(7 - i), 32'h0);
    drive(1'b0, 1'b0, 32'd0, 32'h0);
    drain();
    chk("stream_fires", 64'(nfire - f0), 64'd8);
    if (fire_cyc.size() == 8 && resp_cyc.size() == 8) begin
      chk("stream_ready", 64'(fire_cyc[7] - fire_cyc[0]), 64'd7);
      c0 = fire_cyc[0];
      for (int i = 0; i < 8; i++)
        chk("stream_lat", 64'(resp_cyc[i]), 64'(c0 + 2 + i));
    end else begin
      chk("stream_count", 64'(resp_cyc.size()), 64'd8);
    end

    // Backpressure: only three requests fit.
    resp_ready = 1'b0;
    f0 = nfire;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 32'(i), 32'h0);
    chk("bp_fires", 64'(nfire - f0), 64'd3);
    chk("bp_ready", {63'd0, req_ready}, 64'd0);
    drive(1'b0, 1'b0, 32'd0, 32'h0);
    drain();
    step(1);
    chk("bp_ready_back", {63'd0, req_ready}, 64'd1);

    // Simultaneous push and pop at occupancy 2.
    resp_ready = 1'b0;
    drive(1'b1, 1'b0, 32'd1, 32'h0);
    drive(1'b1, 1'b0, 32'd2, 32'h0);
    drive(1'b0, 1'b0, 32'd0, 32'h0);
    step(3);
    drive(1'b1, 1'b0, 32'd3, 32'h0);
    drive(1'b0, 1'b0, 32'd0, 32'h0);
    resp_ready = 1'b1;
    step(1);
    resp_ready = 1'b0;
    step(2);
    chk("pp_ready", {63'd0, req_ready}, 64'd1);
    chk("pp_valid", {63'd0, resp_valid}, 64'd1);
    drain();

    // Reset with two buffered entries and one in flight.
    resp_ready = 1'b0;
    drive(1'b1, 1'b0, 32'd4, 32'h0);
    drive(1'b1, 1'b0, 32'd6, 32'h0);
    drive(1'b0, 1'b0, 32'd0, 32'h0);
    step(3);
    drive(1'b1, 1'b0, 32'd0, 32'h0);
    drive(1'b0, 1'b0, 32'd0, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {63'd0, resp_valid}, 64'd0);
    chk("mid_rst_ready", {63'd0, req_ready}, 64'd0);
    chk("mid_rst_data", {32'd0, resp_data}, 64'd0);
    sb.delete();
    step(2);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rel_ready", {63'd0, req_ready}, 64'd1);
    resp_ready = 1'b1;
    rv0 = n_rv;
    step(6);
    chk("no_stale", 64'(n_rv - rv0), 64'd0);

    chk("sb_final", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
